// File: rtl/div_check_mul.sv
// ---------------------------------------------------------------------------
// div_check_mul
//
// Rebuilds the dividend of a W-bit division from its quotient, divisor and
// remainder: A = S*B + R. The product is formed by shift-and-add over W RUN
// cycles, one multiplier bit per cycle, with the accumulator preloaded by R.
// The unit also reports whether the operand set could have come from a
// valid W-bit division: ovf when the rebuilt dividend does not fit in W bits,
// err when the remainder is inconsistent with the divisor.
//
// Ports
//   clk    in   1     rising-edge clock
//   rst_n  in   1     synchronous active-low reset
//   start  in   1     request; S, B and R are sampled on the same edge
//   S      in   W     quotient (multiplier)
//   B      in   W     divisor (multiplicand)
//   R      in   W     remainder (addend)
//   busy   out  1     high for the W RUN cycles
//   done   out  1     one-cycle pulse when A and ovf are valid
//   A      out  2W    rebuilt dividend, held until the next result
//   ovf    out  1     A does not fit in W bits
//   err    out  1     B == 0 or R >= B, updated when a request is accepted
// ---------------------------------------------------------------------------
module div_check_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   S,
    input  logic [W-1:0]   B,
    input  logic [W-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] A,
    output logic           ovf,
    output logic           err
);

    localparam int AW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    s_r;
    logic [W-1:0]    b_r;
    logic [AW-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;

    logic [AW-1:0]   addend_s;
    logic [AW-1:0]   acc_step_s;
    logic            last_s;
    logic            accept_s;
    logic            err_s;

    // Datapath step for the current RUN cycle plus request decode.
    always_comb begin
        addend_s   = {{W{1'b0}}, b_r} << cnt_r;
        // The sum never exceeds 2^(2W)-1 because S*B + R fits in 2W bits.
        if (s_r[0]) begin
            acc_step_s = acc_r + addend_s;
        end else begin
            acc_step_s = acc_r;
        end
        last_s = (cnt_r == CW'(W - 1));
        // A request is only taken when no computation is in flight.
        if (start && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // R >= B already covers B == 0; both kept for readability.
        err_s = (B == {W{1'b0}}) || (R >= B);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            s_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            acc_r   <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            A       <= {AW{1'b0}};
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        s_r     <= S;
                        b_r     <= B;
                        acc_r   <= {{W{1'b0}}, R};
                        cnt_r   <= {CW{1'b0}};
                        err     <= err_s;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // Start requests arriving here are dropped, not queued.
                    acc_r <= acc_step_s;
                    s_r   <= s_r >> 1;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        // Publish on the transition so A is valid in DONE.
                        A       <= acc_step_s;
                        ovf     <= |acc_step_s[AW-1:W];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    div_check_mul_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .busy  (busy),
        .done  (done)
    );

endmodule

// ---------------------------------------------------------------------------
// div_check_mul_chk
//
// Protocol properties of div_check_mul outputs.
//
// Ports
//   clk, rst_n  in  clock and synchronous active-low reset
//   busy, done  in  observed status outputs
// ---------------------------------------------------------------------------
module div_check_mul_chk (
    input logic clk,
    input logic rst_n,
    input logic busy,
    input logic done
);

    // busy and done are mutually exclusive.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && done));

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule
